biu_arbiter: RTL and testbench

Bus interface arbiter that shares the single 16-bit memory port between the instruction prefetch unit and the execution unit (EU) data path. It sits between both requesters and the memory IO synchronization interface. It grants one transaction at a time: EU has fixed priority, with a starvation guard for prefetch. It also enforces a one-cycle ack turnaround and a bus timeout.

---
 rtl/biu_arbiter.sv | 128 ++++++++++++
 tb/tb_biu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_arbiter.sv
// Shares the single 16-bit memory port between instruction prefetch and the EU.
// EU has fixed priority; prefetch is forced in after STARVE back-to-back EU grants.
module biu_arbiter #(
    parameter int unsigned STARVE = 4,
    parameter int unsigned TMO    = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        preq,
    input  logic [19:0] padr,
    output logic        pack,
    output logic [15:0] pdtr,

    input  logic        ereq,
    input  logic        ewe,
    input  logic [1:0]  ebe,
    input  logic [19:0] eadr,
    input  logic [15:0] edto,
    output logic        eack,
    output logic [15:0] edtr,

    output logic        berr,

    output logic        mreq,
    output logic        mwe,
    output logic [1:0]  mbe,
    output logic [19:0] madr,
    output logic [15:0] mdto,
    input  logic        mack,
    input  logic [15:0] mdtr
);

    localparam logic [3:0] STARVE_N = 4'(STARVE);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    localparam bit         TMO_EN   = (TMO != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        owner;
    logic [3:0]  scnt;
    logic [7:0]  tcnt;

    logic        grant_p;
    logic        timeout;
    logic [15:0] resp_data;

    always_comb begin
        grant_p   = preq && (!ereq || (scnt == STARVE_N));
        timeout   = TMO_EN && (tcnt == TMO_LAST);
        resp_data = mack ? mdtr : 16'hFFFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            scnt  <= '0;
            tcnt  <= '0;
            pack  <= 1'b0;
            pdtr  <= '0;
            eack  <= 1'b0;
            edtr  <= '0;
            berr  <= 1'b0;
            mreq  <= 1'b0;
            mwe   <= 1'b0;
            mbe   <= '0;
            madr  <= '0;
            mdto  <= '0;
        end else begin
            pack <= 1'b0;
            pdtr <= '0;
            eack <= 1'b0;
            edtr <= '0;
            berr <= 1'b0;

            case (state)
                IDLE: begin
                    if (ereq || preq) begin
                        owner <= grant_p;
                        // Only a contested EU win counts toward starvation.
                        scnt  <= (ereq && preq && !grant_p) ? scnt + 4'd1 : '0;
                        tcnt  <= '0;
                        mreq  <= 1'b1;
                        madr  <= grant_p ? padr : eadr;
                        mwe   <= grant_p ? 1'b0 : ewe;
                        mbe   <= grant_p ? 2'b11 : ebe;
                        mdto  <= grant_p ? 16'h0000 : edto;
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    if (mack || timeout) begin
                        state <= RESP;
                        mreq  <= 1'b0;
                        berr  <= !mack;
                        if (owner) begin
                            pack <= 1'b1;
                            pdtr <= resp_data;
                        end else begin
                            eack <= 1'b1;
                            edtr <= mwe ? 16'h0000 : resp_data;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                RESP: begin
                    tcnt  <= '0;
                    state <= IDLE;
                end

                default: begin
                    mreq  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench for biu_arbiter: single-owner transfers, starvation guard,
// prefetch flush, bus timeout and asynchronous reset.
module tb_biu_arbiter;

    logic        clk;
    logic        rst;
    logic        preq;
    logic [19:0] padr;
    logic        pack;
    logic [15:0] pdtr;
    logic        ereq;
    logic        ewe;
    logic [1:0]  ebe;
    logic [19:0] eadr;
    logic [15:0] edto;
    logic        eack;
    logic [15:0] edtr;
    logic        berr;
    logic        mreq;
    logic        mwe;
    logic [1:0]  mbe;
    logic [19:0] madr;
    logic [15:0] mdto;
    logic        mack;
    logic [15:0] mdtr;

    int n_checks = 0;
    int n_fails  = 0;

    biu_arbiter #(.STARVE(4), .TMO(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .preq (preq),
        .padr (padr),
        .pack (pack),
        .pdtr (pdtr),
        .ereq (ereq),
        .ewe  (ewe),
        .ebe  (ebe),
        .eadr (eadr),
        .edto (edto),
        .eack (eack),
        .edtr (edtr),
        .berr (berr),
        .mreq (mreq),
        .mwe  (mwe),
        .mbe  (mbe),
        .madr (madr),
        .mdto (mdto),
        .mack (mack),
        .mdtr (mdtr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_mem(input logic [15:0] d);
        mack = 1'b1;
        mdtr = d;
        tick();
        mack = 1'b0;
        mdtr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [9:0] pat;
    logic [15:0] d;
    int w;
    int hi;
    logic acc;

    initial begin
        rst  = 1'b1;
        preq = 1'b0; padr = '0;
        ereq = 1'b0; ewe = 1'b0; ebe = '0; eadr = '0; edto = '0;
        mack = 1'b0; mdtr = '0;

        // reset state
        tick(); tick();
        check("rst_mreq", mreq, 0);
        check("rst_pack", pack, 0);
        check("rst_eack", eack, 0);
        check("rst_berr", berr, 0);
        check("rst_madr", madr, 0);
        check("rst_mbe",  mbe,  0);
        rst = 1'b0;
        tick();

        // prefetch alone, memory acks after 2 cycles
        preq = 1'b1; padr = 20'h00100;
        tick();
        check("pf_mreq", mreq, 1);
        check("pf_madr", madr, 20'h00100);
        check("pf_mwe",  mwe,  0);
        check("pf_mbe",  mbe,  2'b11);
        tick();
        check("pf_mreq2", mreq, 1);
        check("pf_pack_early", pack, 0);
        ack_mem(16'hBEEF);
        check("pf_pack", pack, 1);
        check("pf_pdtr", pdtr, 16'hBEEF);
        check("pf_eack", eack, 0);
        check("pf_berr", berr, 0);
        check("pf_resp_mreq", mreq, 0);
        preq = 1'b0;
        tick();
        check("pf_pack_off", pack, 0);
        check("pf_pdtr_off", pdtr, 0);
        tick();
        check("pf_idle_mreq", mreq, 0);

        // EU byte write, zero-wait memory
        ereq = 1'b1; ewe = 1'b1; ebe = 2'b01; eadr = 20'h0A000; edto = 16'h1234;
        tick();
        check("wr_mreq", mreq, 1);
        check("wr_madr", madr, 20'h0A000);
        check("wr_mwe",  mwe,  1);
        check("wr_mbe",  mbe,  2'b01);
        check("wr_mdto", mdto, 16'h1234);
        ack_mem(16'hDEAD);
        check("wr_eack", eack, 1);
        check("wr_edtr", edtr, 0);
        check("wr_pack", pack, 0);
        ereq = 1'b0;
        tick();
        check("wr_eack_off", eack, 0);
        tick();

        // starvation guard: both requesting continuously
        pat  = 10'b1000010000;
        ereq = 1'b1; ewe = 1'b0; ebe = 2'b11; eadr = 20'h00E00; edto = '0;
        preq = 1'b1; padr = 20'h00F00;
        for (int i = 0; i < 10; i++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!mreq && w < 6);
            check("st_wait", w, (i == 0) ? 1 : 2);
            check("st_owner", madr, pat[i] ? 20'h00F00 : 20'h00E00);
            d = 16'h1000 + 16'(i);
            ack_mem(d);
            check("st_pack", pack, pat[i]);
            check("st_eack", eack, !pat[i]);
            check("st_data", pat[i] ? pdtr : edtr, d);
        end
        preq = 1'b0; ereq = 1'b0;
        tick(); tick();
        check("st_idle_mreq", mreq, 0);

        // prefetch flush: preq drops in BUSY, EU waits for RESP
        preq = 1'b1; padr = 20'h00200;
        tick();
        check("fl_mreq", mreq, 1);
        check("fl_madr", madr, 20'h00200);
        preq = 1'b0;
        ereq = 1'b1; ewe = 1'b0; ebe = 2'b11; eadr = 20'h00300;
        tick();
        check("fl_hold_mreq", mreq, 1);
        check("fl_hold_madr", madr, 20'h00200);
        tick();
        check("fl_hold_mreq2", mreq, 1);
        ack_mem(16'hCAFE);
        check("fl_pack", pack, 1);
        check("fl_pdtr", pdtr, 16'hCAFE);
        check("fl_eack", eack, 0);
        check("fl_resp_mreq", mreq, 0);
        tick();
        check("fl_no_grant_in_resp", mreq, 0);
        check("fl_pack_once", pack, 0);
        tick();
        check("fl_eu_mreq", mreq, 1);
        check("fl_eu_madr", madr, 20'h00300);
        ack_mem(16'h5A5A);
        check("fl_eu_eack", eack, 1);
        check("fl_eu_edtr", edtr, 16'h5A5A);
        ereq = 1'b0;
        tick(); tick();
        check("fl_no_dup", mreq, 0);

        // timeout: EU read, memory never acks
        ereq = 1'b1; ewe = 1'b0; ebe = 2'b11; eadr = 20'h00400;
        tick();
        hi = 0;
        while (mreq && hi < 20) begin
            hi++;
            tick();
        end
        check("to_mreq_cycles", hi, 8);
        check("to_eack", eack, 1);
        check("to_berr", berr, 1);
        check("to_edtr", edtr, 16'hFFFF);
        check("to_pack", pack, 0);
        ereq = 1'b0;
        tick();
        check("to_eack_off", eack, 0);
        check("to_berr_off", berr, 0);
        check("to_edtr_off", edtr, 0);
        ack_mem(16'h1111);
        check("stray_pack", pack, 0);
        check("stray_eack", eack, 0);
        check("stray_mreq", mreq, 0);
        preq = 1'b1; padr = 20'h00500;
        tick();
        check("to_next_mreq", mreq, 1);
        check("to_next_madr", madr, 20'h00500);
        ack_mem(16'h0123);
        check("to_next_pack", pack, 1);
        check("to_next_berr", berr, 0);
        check("to_next_pdtr", pdtr, 16'h0123);
        preq = 1'b0;
        tick(); tick();

        // asynchronous reset in BUSY
        ereq = 1'b1; ewe = 1'b1; ebe = 2'b10; eadr = 20'h00600; edto = 16'h7777;
        tick();
        check("ar_mreq", mreq, 1);
        check("ar_mbe", mbe, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("ar_mreq_async", mreq, 0);
        ereq = 1'b0;
        mack = 1'b1; mdtr = 16'h9999;
        tick();
        mack = 1'b0; mdtr = '0;
        rst = 1'b0;
        acc = 1'b0;
        repeat (4) begin
            tick();
            acc = acc | pack | eack | berr | mreq;
        end
        check("ar_no_ack", acc, 0);
        check("ar_madr", madr, 0);
        check("ar_mdto", mdto, 0);
        check("ar_mwe",  mwe,  0);
        check("ar_mbe0", mbe,  0);
        check("ar_pdtr", pdtr, 0);
        check("ar_edtr", edtr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
